// File: rtl/alu_sekw_if.sv
// Operand/result bundle for alu_sekw; the uzyjAcc line exists only when
// ALU_SEKW_ACC_EN is defined.
interface alu_sekw_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OPW   = 3
);
   logic             start;
   logic [WIDTH-1:0] liczbaA;
   logic [WIDTH-1:0] liczbaB;
   logic [OPW-1:0]   wybor;
   logic             bitP;
`ifdef ALU_SEKW_ACC_EN
   logic             uzyjAcc;
`endif
   logic             busy;
   logic             gotowy;
   logic [WIDTH-1:0] wynik;
   logic [WIDTH-1:0] wynikH;
   logic             C;
   logic             EVEN;
   logic             Z;
   logic             OV;

   modport master (
`ifdef ALU_SEKW_ACC_EN
      output uzyjAcc,
`endif
      output start, liczbaA, liczbaB, wybor, bitP,
      input  busy, gotowy, wynik, wynikH, C, EVEN, Z, OV
   );

   modport slave (
`ifdef ALU_SEKW_ACC_EN
      input  uzyjAcc,
`endif
      input  start, liczbaA, liczbaB, wybor, bitP,
      output busy, gotowy, wynik, wynikH, C, EVEN, Z, OV
   );
endinterface

// File: rtl/alu_sekw.sv
// Registered WIDTH-bit ALU with start/busy/gotowy handshake and shift-add multiply.
// Optional accumulator operand source enabled by ALU_SEKW_ACC_EN.
module alu_sekw #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OPW   = 3
) (
   input logic       clk,
   input logic       rst,
   alu_sekw_if.slave bus_io
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [OPW-1:0]     op_q;
   logic               bitp_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CntW-1:0]    cnt_q;
   logic               busy_q, gotowy_q;
   logic [WIDTH-1:0]   wynik_q, wynikh_q;
   logic               c_q, even_q, z_q, ov_q;
`ifdef ALU_SEKW_ACC_EN
   logic [WIDTH-1:0]   acc_q;
`endif

   logic [WIDTH:0]     add_w, sub_w, mac_w;
   logic [WIDTH-1:0]   res_w, res_h, op_a;
   logic               res_c, res_ov, accept;

   // Result of the captured operation; published on the edge that leaves StDone.
   always_comb begin
      add_w  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, bitp_q};
      sub_w  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, bitp_q};
      mac_w  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      res_w  = '0;
      res_h  = '0;
      res_c  = 1'b0;
      res_ov = 1'b0;
      case (op_q)
         3'b000: begin
            res_w  = add_w[WIDTH-1:0];
            res_c  = add_w[WIDTH];
            res_ov = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'b001: begin
            res_w  = sub_w[WIDTH-1:0];
            res_c  = sub_w[WIDTH];
            res_ov = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'b010: res_w = a_q & b_q;
         3'b011: res_w = a_q | b_q;
         3'b100: res_w = a_q ^ b_q;
         3'b101: begin
            res_w  = {a_q[WIDTH-2:0], bitp_q};
            res_c  = a_q[WIDTH-1];
            res_ov = a_q[WIDTH-1] ^ a_q[WIDTH-2];
         end
         3'b110: begin
            res_w = {bitp_q, a_q[WIDTH-1:1]};
            res_c = a_q[0];
         end
         default: begin
            res_w  = prod_q[WIDTH-1:0];
            res_h  = prod_q[2*WIDTH-1:WIDTH];
            res_ov = |prod_q[2*WIDTH-1:WIDTH];
         end
      endcase
   end

   always_comb begin
      accept = bus_io.start && (state_q != StMul);
`ifdef ALU_SEKW_ACC_EN
      // Back-to-back issue must see the value being written into the accumulator now.
      if (bus_io.uzyjAcc) op_a = (state_q == StDone) ? res_w : acc_q;
      else                op_a = bus_io.liczbaA;
`else
      op_a = bus_io.liczbaA;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         bitp_q   <= 1'b0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         gotowy_q <= 1'b0;
         wynik_q  <= '0;
         wynikh_q <= '0;
         c_q      <= 1'b0;
         even_q   <= 1'b1;
         z_q      <= 1'b1;
         ov_q     <= 1'b0;
`ifdef ALU_SEKW_ACC_EN
         acc_q    <= '0;
`endif
      end else begin
         gotowy_q <= 1'b0;
         if (state_q == StDone) begin
            gotowy_q <= 1'b1;
            wynik_q  <= res_w;
            wynikh_q <= res_h;
            c_q      <= res_c;
            ov_q     <= res_ov;
            z_q      <= (res_w == '0);
            even_q   <= ~^res_w;
`ifdef ALU_SEKW_ACC_EN
            acc_q    <= res_w;
`endif
         end
         if (state_q == StMul) begin
            prod_q <= {mac_w, prod_q[WIDTH-1:1]};
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_q <= StDone;
               busy_q  <= 1'b0;
            end
         end else if (accept) begin
            a_q    <= op_a;
            b_q    <= bus_io.liczbaB;
            op_q   <= bus_io.wybor;
            bitp_q <= bus_io.bitP;
            // Multiplier sits in the low half and shifts out as the product shifts in.
            prod_q <= {{WIDTH{1'b0}}, bus_io.liczbaB};
            if (bus_io.wybor == 3'b111) begin
               state_q <= StMul;
               busy_q  <= 1'b1;
               cnt_q   <= CntW'(WIDTH);
            end else begin
               state_q <= StDone;
            end
         end else if (state_q == StDone) begin
            state_q <= StIdle;
         end
      end
   end

   assign bus_io.busy   = busy_q;
   assign bus_io.gotowy = gotowy_q;
   assign bus_io.wynik  = wynik_q;
   assign bus_io.wynikH = wynikh_q;
   assign bus_io.C      = c_q;
   assign bus_io.EVEN   = even_q;
   assign bus_io.Z      = z_q;
   assign bus_io.OV     = ov_q;
endmodule

// File: tb/tb_alu_sekw.sv
// Scoreboard bench for alu_sekw: driver pushes model results, monitor checks each gotowy.
module tb_alu_sekw;
   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] w;
      logic [W-1:0] wh;
      logic         c, ov, z, ev;
      logic         has_lit;
      logic [W-1:0] lit;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sekw_if #(.WIDTH(W)) bus ();
   alu_sekw #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus_io(bus));

   exp_t         sb_q[$];
   exp_t         got;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] acc_m = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op, input logic bp);
      exp_t e;
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint unsigned ubp = bp;
      longint unsigned r;
      e.wh = '0; e.c = 1'b0; e.ov = 1'b0; e.has_lit = 1'b0; e.lit = '0; e.due = 0;
      case (op)
         3'd0: begin
            r = ua + ub + ubp;
            e.w = W'(r);
            e.c = (r >= (64'd1 << W));
            e.ov = (a[W-1] == b[W-1]) && (e.w[W-1] != a[W-1]);
         end
         3'd1: begin
            r = ua - ub - ubp;
            e.w = W'(r);
            e.c = (ua < ub + ubp);
            e.ov = (a[W-1] != b[W-1]) && (e.w[W-1] != a[W-1]);
         end
         3'd2: e.w = a & b;
         3'd3: e.w = a | b;
         3'd4: e.w = a ^ b;
         3'd5: begin
            e.w = W'(ua * 2 + ubp);
            e.c = a[W-1];
            e.ov = a[W-1] ^ a[W-2];
         end
         3'd6: begin
            e.w = W'((ua >> 1) + (ubp << (W - 1)));
            e.c = a[0];
         end
         default: begin
            r = ua * ub;
            e.w = W'(r);
            e.wh = W'(r >> W);
            e.ov = (e.wh != 0);
         end
      endcase
      e.z  = (e.w == 0);
      e.ev = ($countones(e.w) % 2) == 0;
      return e;
   endfunction

   // Called at a negedge; the following posedge is the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic bp, input logic uz, input logic has_lit,
                        input logic [W-1:0] lit);
      exp_t e;
      logic [W-1:0] a_eff;
      a_eff = a;
`ifdef ALU_SEKW_ACC_EN
      if (uz) a_eff = acc_m;
      bus.uzyjAcc = uz;
`endif
      bus.liczbaA = a;
      bus.liczbaB = b;
      bus.wybor   = op;
      bus.bitP    = bp;
      bus.start   = 1'b1;
      e = model(a_eff, b, op, bp);
      e.has_lit = has_lit;
      e.lit = lit;
      e.due = cyc + 1 + ((op == 3'd7) ? W + 1 : 1);
      acc_m = e.w;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic bp, input logic has_lit, input logic [W-1:0] lit);
      @(negedge clk);
      issue(a, b, op, bp, 1'b0, has_lit, lit);
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_wynik", bus.wynik, 0);
      chk("rst_wynikH", bus.wynikH, 0);
      chk("rst_Z", bus.Z, 1);
      chk("rst_EVEN", bus.EVEN, 1);
      chk("rst_C", bus.C, 0);
      chk("rst_OV", bus.OV, 0);
      chk("rst_gotowy", bus.gotowy, 0);
      chk("rst_busy", bus.busy, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.gotowy) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gotowy: got wynik %0h, expected no result", bus.wynik);
         end else begin
            got = sb_q.pop_front();
            chk("latency", cyc, got.due);
            chk("wynik", bus.wynik, got.w);
            chk("wynikH", bus.wynikH, got.wh);
            chk("C", bus.C, got.c);
            chk("OV", bus.OV, got.ov);
            chk("Z", bus.Z, got.z);
            chk("EVEN", bus.EVEN, got.ev);
            if (got.has_lit) chk("wynik_directed", bus.wynik, got.lit);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      logic [2:0] op;
      bus.start = 1'b0; bus.liczbaA = '0; bus.liczbaB = '0; bus.wybor = '0; bus.bitP = 1'b0;
`ifdef ALU_SEKW_ACC_EN
      bus.uzyjAcc = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b0;

      do_op(8'h05, 8'h03, 3'd0, 1'b0, 1'b1, 8'h08);
      do_op(8'h05, 8'h03, 3'd0, 1'b1, 1'b1, 8'h09);
      do_op(8'h85, 8'h87, 3'd0, 1'b0, 1'b1, 8'h0C);
      do_op(8'h01, 8'h81, 3'd1, 1'b0, 1'b1, 8'h80);

      // Multiply with an ignored start pulse while busy.
      @(negedge clk);
      issue(8'hFF, 8'h81, 3'd7, 1'b0, 1'b0, 1'b1, 8'h7F);
      busy_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (i == 2) begin
            bus.liczbaA = 8'h11; bus.liczbaB = 8'h22; bus.wybor = 3'd0; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("mul_busy_cycles", busy_cnt, W);
      wait_idle();

      // Reset in the middle of a multiply.
      @(negedge clk);
      issue(8'hFF, 8'h81, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      sb_q.delete();
      acc_m = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      do_op(8'h05, 8'h03, 3'd0, 1'b0, 1'b1, 8'h08);

      // Back-to-back single-cycle ops with start held.
      @(negedge clk);
      issue(8'hF0, 8'h3C, 3'd2, 1'b0, 1'b0, 1'b1, 8'h30);
      @(negedge clk);
      issue(8'hF0, 8'h3C, 3'd3, 1'b0, 1'b0, 1'b1, 8'hFC);
      @(negedge clk);
      issue(8'hF0, 8'h3C, 3'd4, 1'b0, 1'b0, 1'b1, 8'hCC);
`ifdef ALU_SEKW_ACC_EN
      @(negedge clk);
      issue(8'h00, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 8'hCD);
`endif
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // Randomised traffic, sometimes chained back-to-back.
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         issue(W'($urandom), W'($urandom), op, 1'($urandom), 1'($urandom), 1'b0, 8'h00);
         @(negedge clk);
         if (op == 3'd7 || $urandom_range(0, 3) == 0) begin
            bus.start = 1'b0;
            wait_idle();
            @(negedge clk);
         end
      end
      bus.start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_sekw.md
Name: alu_sekw

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU (`main`).
- Generalised to WIDTH bits and a 3-bit opcode. Adds a start/busy/gotowy handshake and a multi-cycle shift-add multiply.
- Flags C, EVEN, Z and OV are registered with the result.
- Sits between the operand register file and the result/flag latch of the datapath.

Parameters:
- WIDTH, 8: operand and result width, 4 to 32.
- OPW, 3: opcode width; fixed, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled on clk while the block is not busy.
- liczbaA  in  WIDTH  operand A, captured at accepted start.
- liczbaB  in  WIDTH  operand B, captured at accepted start.
- wybor  in  OPW  opcode, captured at accepted start.
- bitP  in  1  carry/borrow/shift-in bit, captured at accepted start.
- busy  out  1  high while in state MUL.
- gotowy  out  1  one-cycle pulse: wynik, wynikH and the flags are new.
- wynik  out  WIDTH  result, low half for multiply.
- wynikH  out  WIDTH  high half of the multiply product; 0 for all other ops.
- C  out  1  carry/borrow/shifted-out bit.
- EVEN  out  1  1 when wynik has an even number of ones.
- Z  out  1  1 when wynik == 0.
- OV  out  1  signed overflow; for multiply, wynikH != 0.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, busy=0, gotowy=0, wynik=0, wynikH=0, C=0, OV=0, Z=1, EVEN=1 (consistent with wynik=0).
- Reset mid-multiply aborts the operation; no gotowy is produced for it.
- States:
  - IDLE: start=1 captures the operands. wybor=111 goes to MUL; any other opcode goes to DONE.
  - MUL: WIDTH iterations, one per clock. Each iteration: if multiplier LSB=1, add the multiplicand into the 2*WIDTH product; then shift. Go to DONE after the last iteration.
  - DONE: gotowy=1 for exactly one cycle, outputs updated.
    - start=1 here is accepted and treated as in IDLE, so back-to-back issue works.
    - Otherwise return to IDLE.
- Latency from the accepting edge to the gotowy cycle: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply.
- start while busy=1 is ignored: not queued, no error. Operand changes after capture have no effect.
- Outputs hold their last values until the next DONE.
- Opcodes, computed at WIDTH+1 bits:
  - 000 add: A+B+bitP. C = carry out. OV = (A[msb]==B[msb]) && (wynik[msb]!=A[msb]).
  - 001 sub: A-B-bitP. C = borrow (1 when A < B+bitP, unsigned). OV = (A[msb]!=B[msb]) && (wynik[msb]!=A[msb]).
  - 010 AND; 011 OR; 100 XOR: C=0, OV=0.
  - 101 shl: wynik = {A[WIDTH-2:0], bitP}, C = A[msb], OV = A[msb]^A[msb-1].
  - 110 shr: wynik = {bitP, A[WIDTH-1:1]}, C = A[0], OV=0.
  - 111 mul: unsigned. {wynikH, wynik} = A*B, C=0, OV = |wynikH.
- Z and EVEN always derive from wynik only, never from wynikH.

Optional Feature:
- Macro: ALU_SEKW_ACC_EN.
- Defined:
  - Adds an internal WIDTH-bit accumulator, reset to 0 and loaded with wynik at every DONE.
  - Adds input port uzyjAcc (1 bit, sampled with start). When uzyjAcc=1, the accumulator replaces liczbaA as operand A.
  - Reset clears the accumulator.
- Undefined: no accumulator and no uzyjAcc port; operand A is always liczbaA.

Test Plan:
- Reset with all inputs 0 → wynik=0, Z=1, EVEN=1, C=0, OV=0, gotowy=0, busy=0.
- add, A=0x05, B=0x03, bitP=0 → one cycle later: gotowy pulse, wynik=0x08, C=0, Z=0, EVEN=0, OV=0. Same with bitP=1 → wynik=0x09, EVEN=1.
- add, A=0x85, B=0x87 → wynik=0x0C, C=1, OV=1. Then sub, A=0x01, B=0x81 → wynik=0x80, C=1, OV=1.
- mul, A=0xFF, B=0x81 → busy for 8 cycles, gotowy 9 cycles after start, wynikH=0x80, wynik=0x7F, OV=1. A second start pulsed during busy is ignored.
- mul started, rst asserted after 4 cycles → outputs return to reset values immediately, no gotowy. The next add (0x05, 0x03) completes normally with wynik=0x08.
- Back-to-back: start held over 3 cycles with and/or/xor of 0xF0, 0x3C → gotowy on 3 consecutive cycles with wynik 0x30, 0xFC, 0xCC. With ALU_SEKW_ACC_EN defined, then add with uzyjAcc=1, B=0x01 → wynik=0xCD.
